pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage of the pipelined RV32 core. It holds the fetch PC, generates the sequential next PC internally, and applies branch/jump and trap redirects with fixed priority. Redirects that arrive while fetch is stalled by `busyWait` are captured and applied when the stall releases, so none are lost. It also exports a count of accepted fetch addresses for performance monitoring.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_redirect_latch.sv | 64 ++++++
 rtl/pc_unit.sv | 127 ++++++++++++
 tb/tb_pc_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// ============================================================================
// Module : pc_pkg
// Shared types and constants for the fetch-stage program-counter unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pc_pkg;

  localparam int unsigned            PC_XLEN_DEFAULT         = 32;
  localparam logic [31:0]            PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_t;

  // Mask that clears the low log2(inc) bits; callers slice it down to XLEN.
  function automatic logic [63:0] align_mask(input int unsigned inc);
    return ~(64'(inc) - 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_redirect_latch.sv
// ============================================================================
// Module : pc_redirect_latch
// Holds a redirect captured during a fetch stall until the stall releases.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_redirect_latch
  import pc_pkg::*;
#(
  parameter int XLEN = PC_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            pend,
  input  logic            stall,
  input  logic            trap_taken,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] trap_target,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] target_q,
  output logic            is_trap_q
);

  logic [XLEN-1:0] target_d;
  logic            is_trap_d;

  // Once pending, only a trap may replace the held target; younger branches are flushed.
  always_comb begin
    target_d  = target_q;
    is_trap_d = is_trap_q;
    if (run && stall) begin
      if (trap_taken) begin
        target_d  = trap_target;
        is_trap_d = 1'b1;
      end else if (branch_taken) begin
        target_d  = branch_target;
        is_trap_d = 1'b0;
      end
    end else if (pend && stall) begin
      if (trap_taken) begin
        target_d  = trap_target;
        is_trap_d = 1'b1;
      end
    end else if (pend && !stall) begin
      target_d  = '0;
      is_trap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q  <= '0;
      is_trap_q <= 1'b0;
    end else begin
      target_q  <= target_d;
      is_trap_q <= is_trap_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// Module : pc_unit
// Fetch PC register with sequential increment, prioritised redirects and a
// stall-safe pending redirect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = PC_XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEFAULT),
  parameter int              INC          = 4,
  parameter int              CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             busyWait,
  input  logic             branchTaken,
  input  logic [XLEN-1:0]  branchTarget,
  input  logic             trapTaken,
  input  logic [XLEN-1:0]  trapVector,
  output logic [XLEN-1:0]  PC,
  output logic             pcValid,
  output logic             redirectPending,
  output logic [CNT_W-1:0] fetchCount
);

  localparam logic [63:0]     ALIGN_MASK_FULL = align_mask(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK      = ALIGN_MASK_FULL[XLEN-1:0];
  localparam logic [XLEN-1:0] INC_VAL         = XLEN'(INC);

  pc_state_t        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             redirect_pending_q, redirect_pending_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic [XLEN-1:0]  trap_aligned;
  logic [XLEN-1:0]  branch_aligned;
  logic [XLEN-1:0]  pc_inc;
  logic [XLEN-1:0]  pend_target;
  logic             pend_is_trap;

  assign trap_aligned   = trapVector & ALIGN_MASK;
  assign branch_aligned = branchTarget & ALIGN_MASK;
  assign pc_inc         = pc_q + INC_VAL;

  pc_redirect_latch #(
    .XLEN (XLEN)
  ) u_redirect_latch (
    .clk           (CLK),
    .rst           (RESET),
    .run           (state_q == RUN),
    .pend          (state_q == PEND),
    .stall         (busyWait),
    .trap_taken    (trapTaken),
    .branch_taken  (branchTaken),
    .trap_target   (trap_aligned),
    .branch_target (branch_aligned),
    .target_q      (pend_target),
    .is_trap_q     (pend_is_trap)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_valid_d    = pc_valid_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      BOOT: begin
        // PC stays at the reset vector so it is the first address fetched.
        state_d    = RUN;
        pc_valid_d = 1'b1;
      end
      RUN: begin
        if (!busyWait) begin
          if (trapTaken)        pc_d = trap_aligned;
          else if (branchTaken) pc_d = branch_aligned;
          else                  pc_d = pc_inc;
          fetch_count_d = fetch_count_q + CNT_W'(1);
        end else if (trapTaken || branchTaken) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (!busyWait) begin
          pc_d          = trapTaken ? trap_aligned : pend_target;
          fetch_count_d = fetch_count_q + CNT_W'(1);
          state_d       = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    redirect_pending_d = (state_d == PEND);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q            <= BOOT;
      pc_q               <= RESET_VECTOR;
      pc_valid_q         <= 1'b0;
      redirect_pending_q <= 1'b0;
      fetch_count_q      <= '0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      pc_valid_q         <= pc_valid_d;
      redirect_pending_q <= redirect_pending_d;
      fetch_count_q      <= fetch_count_d;
    end
  end

  // The trap flag is only meaningful while a redirect is held.
  always_ff @(posedge CLK) begin
    if (state_q != PEND) assert (!pend_is_trap);
  end

  assign PC              = pc_q;
  assign pcValid         = pc_valid_q;
  assign redirectPending = redirect_pending_q;
  assign fetchCount      = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module : tb_pc_unit
// Scoreboard bench for pc_unit: a 32-bit instance and an 8-bit wrap instance.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst_a = 1'b1, busy_a = 1'b0, br_a = 1'b0, tr_a = 1'b0;
  logic [31:0] bt_a = '0, tv_a = '0;
  logic [31:0] pc_a;
  logic        valid_a, pend_a;
  logic [31:0] cnt_a;

  // 8-bit instance with a 4-bit counter
  logic        rst_b = 1'b1, busy_b = 1'b0, br_b = 1'b0, tr_b = 1'b0;
  logic [7:0]  bt_b = '0, tv_b = '0;
  logic [7:0]  pc_b;
  logic        valid_b, pend_b;
  logic [3:0]  cnt_b;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .INC          (4),
    .CNT_W        (32)
  ) dut_a (
    .CLK             (clk),
    .RESET           (rst_a),
    .busyWait        (busy_a),
    .branchTaken     (br_a),
    .branchTarget    (bt_a),
    .trapTaken       (tr_a),
    .trapVector      (tv_a),
    .PC              (pc_a),
    .pcValid         (valid_a),
    .redirectPending (pend_a),
    .fetchCount      (cnt_a)
  );

  pc_unit #(
    .XLEN         (8),
    .RESET_VECTOR (8'hF0),
    .INC          (4),
    .CNT_W        (4)
  ) dut_b (
    .CLK             (clk),
    .RESET           (rst_b),
    .busyWait        (busy_b),
    .branchTaken     (br_b),
    .branchTarget    (bt_b),
    .trapTaken       (tr_b),
    .trapVector      (tv_b),
    .PC              (pc_b),
    .pcValid         (valid_b),
    .redirectPending (pend_b),
    .fetchCount      (cnt_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare(input string tag, input logic [31:0] pc, input logic valid,
                         input logic pend, input logic [31:0] cnt);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, ".pc"},    pc,           e.pc);
      check_val({tag, ".valid"}, 32'(valid),   32'(e.valid));
      check_val({tag, ".pend"},  32'(pend),    32'(e.pend));
      check_val({tag, ".cnt"},   cnt,          e.cnt);
    end
  endtask

  // Drive one cycle of stimulus on instance A, then compare after the edge.
  task automatic step_a(input string tag, input logic rst, input logic busy,
                        input logic br, input logic [31:0] bt,
                        input logic tr, input logic [31:0] tv,
                        input logic [31:0] e_pc, input logic e_valid,
                        input logic e_pend, input logic [31:0] e_cnt);
    rst_a = rst; busy_a = busy; br_a = br; bt_a = bt; tr_a = tr; tv_a = tv;
    sb_q.push_back('{pc: e_pc, valid: e_valid, pend: e_pend, cnt: e_cnt});
    @(posedge clk);
    #1;
    compare(tag, pc_a, valid_a, pend_a, cnt_a);
  endtask

  task automatic step_b(input string tag, input logic rst, input logic br,
                        input logic [7:0] bt, input logic [7:0] e_pc,
                        input logic e_valid, input logic [3:0] e_cnt);
    rst_b = rst; busy_b = 1'b0; br_b = br; bt_b = bt; tr_b = 1'b0; tv_b = '0;
    sb_q.push_back('{pc: {24'd0, e_pc}, valid: e_valid, pend: 1'b0, cnt: {28'd0, e_cnt}});
    @(posedge clk);
    #1;
    compare(tag, {24'd0, pc_b}, valid_b, pend_b, {28'd0, cnt_b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    //      tag        rst busy br  bt          tr  tv           pc          v  p  cnt
    step_a("reset",   1,  0,   0,  32'h0,      0,  32'h0,       32'h0,      0, 0, 0);
    step_a("boot",    0,  0,   0,  32'h0,      0,  32'h0,       32'h0,      1, 0, 0);
    step_a("seq1",    0,  0,   0,  32'h0,      0,  32'h0,       32'h4,      1, 0, 1);
    step_a("seq2",    0,  0,   0,  32'h0,      0,  32'h0,       32'h8,      1, 0, 2);
    step_a("br103",   0,  0,   1,  32'h103,    0,  32'h0,       32'h100,    1, 0, 3);
    step_a("seq104",  0,  0,   0,  32'h0,      0,  32'h0,       32'h104,    1, 0, 4);
    step_a("stall1",  0,  1,   1,  32'h200,    0,  32'h0,       32'h104,    1, 1, 4);
    step_a("stall2",  0,  1,   1,  32'h300,    0,  32'h0,       32'h104,    1, 1, 4);
    step_a("stall3",  0,  1,   0,  32'h0,      0,  32'h0,       32'h104,    1, 1, 4);
    step_a("stall4",  0,  1,   0,  32'h0,      0,  32'h0,       32'h104,    1, 1, 4);
    step_a("rel200",  0,  0,   0,  32'h0,      0,  32'h0,       32'h200,    1, 0, 5);
    step_a("seq204",  0,  0,   0,  32'h0,      0,  32'h0,       32'h204,    1, 0, 6);
    step_a("pbr200",  0,  1,   1,  32'h200,    0,  32'h0,       32'h204,    1, 1, 6);
    step_a("ptrap80", 0,  1,   0,  32'h0,      1,  32'h80,      32'h204,    1, 1, 6);
    step_a("rel80",   0,  0,   0,  32'h0,      0,  32'h0,       32'h80,     1, 0, 7);
    step_a("trapbr",  0,  0,   1,  32'h500,    1,  32'h40,      32'h40,     1, 0, 8);
    step_a("pbr600",  0,  1,   1,  32'h600,    0,  32'h0,       32'h40,     1, 1, 8);
    step_a("reltrap", 0,  0,   0,  32'h0,      1,  32'hC1,      32'hC0,     1, 0, 9);
    step_a("ptrap2a", 0,  1,   0,  32'h0,      1,  32'h2A7,     32'hC0,     1, 1, 9);
    step_a("pbrign",  0,  1,   1,  32'h700,    0,  32'h0,       32'hC0,     1, 1, 9);
    step_a("rel2a4",  0,  0,   0,  32'h0,      0,  32'h0,       32'h2A4,    1, 0, 10);
    step_a("seq2a8",  0,  0,   0,  32'h0,      0,  32'h0,       32'h2A8,    1, 0, 11);
    step_a("pbr800",  0,  1,   1,  32'h800,    0,  32'h0,       32'h2A8,    1, 1, 11);
    step_a("rstpend", 1,  1,   1,  32'h800,    0,  32'h0,       32'h0,      0, 0, 0);
    step_a("bootbsy", 0,  1,   1,  32'h900,    0,  32'h0,       32'h0,      1, 0, 0);
    step_a("pbr10",   0,  1,   1,  32'h10,     0,  32'h0,       32'h0,      1, 1, 0);
    step_a("rel10",   0,  0,   0,  32'h0,      0,  32'h0,       32'h10,     1, 0, 1);

    //      tag       rst br  bt      pc      v  cnt
    step_b("b_reset", 1,  0,  8'h0,   8'hF0,  0, 4'd0);
    step_b("b_boot",  0,  0,  8'h0,   8'hF0,  1, 4'd0);
    step_b("b_seq1",  0,  0,  8'h0,   8'hF4,  1, 4'd1);
    step_b("b_seq2",  0,  0,  8'h0,   8'hF8,  1, 4'd2);
    step_b("b_seqfc", 0,  0,  8'h0,   8'hFC,  1, 4'd3);
    step_b("b_wrap",  0,  0,  8'h0,   8'h00,  1, 4'd4);
    for (int i = 1; i <= 11; i++) begin
      step_b("b_run", 0, 0, 8'h0, 8'(4 * i), 1, 4'(4 + i));
    end
    step_b("b_cntwr", 0,  0,  8'h0,   8'h30,  1, 4'd0);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
